mpu341_loader: RTL and testbench
================================

# mpu341_loader

Program-load controller that sits directly upstream of the MPU341 core. It accepts a framed byte stream over a valid/ready interface and writes the bytes into the 256×8 program memory write port. It holds the core in reset for the whole load and releases it only after the frame checksum verifies. The core then starts fetching at PC 0 from the freshly loaded image.

## Interface

Parameters:
- `BOOT_RUN`, default 0. When 1, the core is released after reset without a load, running the existing memory contents. When 0, the core stays in reset until a successful load.

Ports:
- `clk`, in, 1. Single clock, the same clock as the MPU341 core.
- `reset`, in, 1. Synchronous, active-high.
- `start`, in, 1. Level-sampled each cycle; begins a load frame when the block is in IDLE, RUN or ERROR.
- `rx_data`, in, 8. Stream byte.
- `rx_valid`, in, 1. `rx_data` is valid.
- `rx_ready`, out, 1. Block accepts a byte. A transfer occurs on a rising edge where `rx_valid & rx_ready`.
- `pm_wr_en`, out, 1. Program memory write strobe.
- `pm_wr_addr`, out, 8. Program memory write address.
- `pm_wr_data`, out, 8. Program memory write data.
- `mpu_reset`, out, 1. Drives the `reset` input of the MPU341 core.
- `busy`, out, 1. A load frame is in progress.
- `done`, out, 1. The last load succeeded and the core is running.
- `error`, out, 1. The last load failed its checksum.

## Operation

**Frame format:** one `LEN` byte, then `LEN+1` data bytes, then one checksum byte.
- The checksum is the 8-bit sum, mod 256, of the data bytes only. The `LEN` byte is excluded.
- Frames carry 1 to 256 words.

**States:** IDLE, LEN, DATA, CSUM, RUN, ERROR.
- `rx_ready` is 1 in LEN, DATA and CSUM, and 0 otherwise. It is decoded from the registered state.
- **IDLE:** when `start`=1, go to LEN. Set `busy`=1, `done`=0, `error`=0, clear the running sum, set the word counter to 0, and set `mpu_reset`=1.
- **LEN:** on a transfer, capture `len`=`rx_data` and go to DATA.
- **DATA:** on each transfer:
  - register the write (`pm_wr_en`=1, `pm_wr_addr`=counter, `pm_wr_data`=`rx_data`);
  - add `rx_data` to the sum (8-bit);
  - if counter==`len`, go to CSUM; otherwise increment the counter.
- **CSUM:** on a transfer, compare `rx_data` with the sum.
  - Equal: go to RUN with `mpu_reset`=0, `done`=1, `busy`=0.
  - Not equal: go to ERROR with `error`=1, `busy`=0, and `mpu_reset` held at 1.
- **RUN:** `start`=1 re-enters LEN with the same actions as in IDLE. `mpu_reset` returns to 1 at that edge.
- **ERROR:** `mpu_reset` stays 1. `start`=1 re-enters LEN with the same actions as in IDLE.

**Boundary conditions:**
- `start` is ignored in LEN, DATA and CSUM.
- `rx_valid` is ignored in IDLE, RUN and ERROR; no byte is consumed.
- The counter never wraps. With `len`=FF the final write is to address FF, then the state is CSUM.
- A `len`=00 frame writes exactly one word, at address 00.
- Gaps in `rx_valid` stall the FSM with no side effects, and `pm_wr_en` stays 0 during gaps.
- Reset asserted mid-frame aborts the load. Partially written memory words are not restored.

**Reset values:** state = `BOOT_RUN` ? RUN : IDLE, `mpu_reset`=1, `rx_ready`=0, `pm_wr_en`=0, `pm_wr_addr`=00, `pm_wr_data`=00, `busy`=0, `done`=0, `error`=0.
- With `BOOT_RUN`=1, `mpu_reset` falls one edge after `reset` deasserts, and `done` remains 0.

## Timing

- **Outputs are registered.** All outputs except `rx_ready` are registered.
- **Write latency:** a DATA transfer at edge k makes `pm_wr_en`, `pm_wr_addr` and `pm_wr_data` valid for exactly the cycle after edge k, so they are stable for the program memory's falling-edge capture.
- **Throughput:** one byte per cycle. Back-to-back transfers produce consecutive one-cycle write strobes with no bubbles.
- **Release latency:** a successful checksum transfer at edge k sets `mpu_reset`=0 and `done`=1 after edge k. The core samples its reset synchronously one edge later, so PC 0 is fetched from edge k+2.
- **Last write vs. release:** the final data write always completes before `mpu_reset` falls, because the write is at least one cycle before the checksum transfer.
- **Restart latency:** `start` sampled at edge k gives `busy`=1, `mpu_reset`=1 and `rx_ready`=1 after edge k.

## Test plan

- **Reset:** hold `reset` for 3 cycles with `BOOT_RUN`=0 → all outputs at their reset values; `rx_valid`=1 with `rx_ready`=0 consumes nothing.
- **3-word load:** `start`, then bytes 02, 8A, 1B, C3, 68 back-to-back →
  - writes (00,8A), (01,1B), (02,C3) on consecutive cycles;
  - `done`=1 and `mpu_reset`=0 one cycle after the byte 68 transfer.
- **Bad checksum:** same frame with checksum 69 → `error`=1, `mpu_reset`=1, exactly 3 writes. A new `start` plus a valid frame then gives `done`=1 and `error`=0.
- **Full image:** `len`=FF, 256 data bytes with value equal to address, checksum 80 →
  - 256 writes at addresses 00..FF with no wrap;
  - success.
- **Stall and ignore:** a 2-word frame with `rx_valid` toggling every other cycle and `start` pulsed during DATA → same write contents as an unstalled frame, `pm_wr_en` 0 in the gaps, no restart.
- **Reset mid-load:** assert `reset` after 5 of 10 data bytes → next edge state is IDLE, `pm_wr_en`=0, `busy`=0, `mpu_reset`=1. With `BOOT_RUN`=1, `mpu_reset`=0 one edge after `reset` is released.

Source files
------------

// File: rtl/mpu341_loader.sv
// mpu341_loader: program-load controller for the MPU341 core.
// It receives a framed byte stream (LEN, LEN+1 data bytes, checksum),
// writes the data bytes into the 256x8 program memory, and holds the
// core in reset until the frame checksum verifies.
module mpu341_loader #(
  parameter bit BOOT_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       pm_wr_en,
  output logic [7:0] pm_wr_addr,
  output logic [7:0] pm_wr_data,
  output logic       mpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] cnt;
  logic [7:0] sum;
  logic       xfer;

  // Byte acceptance is decoded straight from the registered state.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rx_ready = 1'b0;
    if (state == S_LEN || state == S_DATA || state == S_CSUM) begin
      rx_ready = 1'b1;
    end
    xfer = rx_valid & rx_ready;
  end

  // Load FSM with all outputs registered; writes strobe for exactly one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT_RUN ? S_RUN : S_IDLE;
      mpu_reset  <= 1'b1;
      pm_wr_en   <= 1'b0;
      pm_wr_addr <= 8'h00;
      pm_wr_data <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      len        <= 8'h00;
      cnt        <= 8'h00;
      sum        <= 8'h00;
    end else begin
      pm_wr_en <= 1'b0;
      unique case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state     <= S_LEN;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            sum       <= 8'h00;
            cnt       <= 8'h00;
            mpu_reset <= 1'b1;
          end else if (state == S_RUN) begin
            // Covers the boot-run case: release the core one edge after reset.
            mpu_reset <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            len   <= rx_data;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            pm_wr_en   <= 1'b1;
            pm_wr_addr <= cnt;
            pm_wr_data <= rx_data;
            sum        <= sum + rx_data;
            // Counter stops at len so a 256-word frame never wraps past FF.
            if (cnt == len) begin
              state <= S_CSUM;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            busy <= 1'b0;
            if (rx_data == sum) begin
              state     <= S_RUN;
              mpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu341_loader.sv
// Self-checking bench for mpu341_loader: directed frames, with expected
// program-memory writes pushed to a scoreboard queue and popped by a monitor.
module tb_mpu341_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       pm_wr_en;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       mpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  // Second instance built with BOOT_RUN=1, kept idle apart from reset.
  logic       b_rx_ready;
  logic       b_pm_wr_en;
  logic [7:0] b_pm_wr_addr;
  logic [7:0] b_pm_wr_data;
  logic       b_mpu_reset;
  logic       b_busy;
  logic       b_done;
  logic       b_error;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] dbuf[256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_count = 0;
  int         cyc      = 0;
  int         w0;

  mpu341_loader #(.BOOT_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .pm_wr_en(pm_wr_en),
    .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
    .mpu_reset(mpu_reset), .busy(busy), .done(done), .error(error)
  );

  mpu341_loader #(.BOOT_RUN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(1'b0), .rx_data(8'h00),
    .rx_valid(1'b0), .rx_ready(b_rx_ready), .pm_wr_en(b_pm_wr_en),
    .pm_wr_addr(b_pm_wr_addr), .pm_wr_data(b_pm_wr_data),
    .mpu_reset(b_mpu_reset), .busy(b_busy), .done(b_done), .error(b_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write, including
  // the cycle it appears in (the cycle right after its transfer edge).
  always @(negedge clk) begin
    if (pm_wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", pm_wr_addr, pm_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, pm_wr_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, pm_wr_data}, {24'd0, e.data});
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one byte and wait (bounded) for its transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input logic [7:0] addr, input bit gap);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (rx_ready !== 1'b1) begin
      check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      return;
    end
    @(posedge clk); #1;
    if (is_data) exp_q.push_back('{addr, b, cyc});
    if (gap) begin
      rx_valid = 1'b0;
      if (is_data) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic send_frame(input int n_words, input logic [7:0] csum, input bit gap);
    send_byte(8'(n_words - 1), 1'b0, 8'h00, gap);
    for (int i = 0; i < n_words; i++) send_byte(dbuf[i], 1'b1, 8'(i), gap);
    send_byte(csum, 1'b0, 8'h00, 1'b0);
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_error", {31'd0, error}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_wr_en", {31'd0, pm_wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, pm_wr_addr}, 32'h00);
    check("rst_wr_data", {24'd0, pm_wr_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("bootrun_rst_mpu_reset", {31'd0, b_mpu_reset}, 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    reset    = 1'b0;
    @(posedge clk); #1;
    check("bootrun_release", {31'd0, b_mpu_reset}, 32'd0);
    check("bootrun_done", {31'd0, b_done}, 32'd0);
    // rx_valid in IDLE must not be consumed
    repeat (2) @(posedge clk);
    #1;
    check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    rx_valid = 1'b0;

    // 3-word load: 8A+1B+C3 = 0x168 -> checksum 68
    dbuf[0] = 8'h8A; dbuf[1] = 8'h1B; dbuf[2] = 8'hC3;
    do_start();
    w0 = wr_count;
    send_frame(3, 8'h68, 1'b0);
    check("load3_done", {31'd0, done}, 32'd1);
    check("load3_mpu_reset", {31'd0, mpu_reset}, 32'd0);
    check("load3_busy", {31'd0, busy}, 32'd0);
    check("load3_error", {31'd0, error}, 32'd0);
    check("load3_writes", wr_count - w0, 32'd3);

    // Bad checksum, then recovery from ERROR
    do_start();
    w0 = wr_count;
    send_frame(3, 8'h69, 1'b0);
    check("bad_error", {31'd0, error}, 32'd1);
    check("bad_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("bad_done", {31'd0, done}, 32'd0);
    check("bad_busy", {31'd0, busy}, 32'd0);
    check("bad_writes", wr_count - w0, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("bad_hold_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    do_start();
    send_frame(3, 8'h68, 1'b0);
    check("recover_done", {31'd0, done}, 32'd1);
    check("recover_error", {31'd0, error}, 32'd0);

    // Full image: data == address, sum 0..255 = 0x7F80 -> checksum 80
    for (int i = 0; i < 256; i++) dbuf[i] = 8'(i);
    do_start();
    w0 = wr_count;
    send_frame(256, 8'h80, 1'b0);
    check("full_writes", wr_count - w0, 32'd256);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_mpu_reset", {31'd0, mpu_reset}, 32'd0);

    // Stalled 2-word frame with start pulses in DATA: 5A+A5 = FF
    dbuf[0] = 8'h5A; dbuf[1] = 8'hA5;
    do_start();
    w0 = wr_count;
    send_frame(2, 8'hFF, 1'b1);
    check("stall_writes", wr_count - w0, 32'd2);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd0);

    // Reset after 5 of 10 data bytes
    for (int i = 0; i < 10; i++) dbuf[i] = 8'(i + 1);
    do_start();
    send_byte(8'h09, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(dbuf[i], 1'b1, 8'(i), 1'b0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_en", {31'd0, pm_wr_en}, 32'd0);
    check("midrst_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_b_mpu_reset", {31'd0, b_mpu_reset}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_b_release", {31'd0, b_mpu_reset}, 32'd0);
    check("midrst_idle_mpu_reset", {31'd0, mpu_reset}, 32'd1);
    check("midrst_idle_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
